axi4_lite_uart_arbiter: RTL and testbench
=========================================

# axi4_lite_uart_arbiter

Two-port AXI4-Lite master that shares the single AXI4-Lite UART slave between two on-chip requesters. It accepts single-word read or write requests on a simple valid/grant/done interface and arbitrates round-robin. It runs exactly one AXI4-Lite transaction at a time, then returns the response and read data to the winner. It sits between the requesters and the UART slave's AXI4-Lite port, one clock domain.

## Interface

- ADDR_WIDTH, 32, AXI address width and requester address width.
- DATA_WIDTH, 32, AXI data width and requester data width.
- aclk  in  1  clock; all logic on rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_write  in  2  per-requester direction: 1 = write, 0 = read.
- req_addr  in  2*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  2*DATA_WIDTH  packed write data, same packing.
- req_grant  out  2  one-hot, one-cycle pulse: request i captured.
- req_done  out  2  one-hot, one-cycle pulse: transaction i complete; rsp_* valid this cycle.
- rsp_rdata  out  DATA_WIDTH  read data of the completed read; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP of the completed transaction.
- m_awaddr, m_awprot(3), m_awvalid  out; m_awready  in  write address channel.
- m_wdata, m_wstrb(4), m_wvalid  out; m_wready  in  write data channel.
- m_bresp(2), m_bvalid  in; m_bready  out  write response channel.
- m_araddr, m_arprot(3), m_arvalid  out; m_arready  in  read address channel.
- m_rdata, m_rresp(2), m_rvalid  in; m_rready  out  read data channel.

## Operation

- States: IDLE, WRITE (AW+W outstanding), WRESP, READ (AR outstanding), RDATA.
- IDLE: if any req_valid, pick a winner, latch its write/addr/wdata, pulse req_grant[winner] next cycle, go to WRITE or READ.
- Round-robin: pointer `last` holds the last-granted index. Both valid: grant `~last`. One valid: grant it. Reset value of `last` = 1, so requester 0 wins the first tie.
- req_valid is sampled only in IDLE. A requester holds valid and payload stable until its grant pulse. It may reassert valid with a new payload after its done.
- WRITE: m_awvalid and m_wvalid assert together. Each drops independently on its own handshake (valid & ready). When both handshakes have completed (same or different cycles), go to WRESP.
- WRESP: m_bready=1. On m_bvalid, capture m_bresp, go to IDLE.
- READ: m_arvalid=1 until m_arready, then RDATA.
- RDATA: m_rready=1. On m_rvalid, capture m_rdata/m_rresp, go to IDLE.
- Completion: req_done[winner] pulses in the cycle after the B/R handshake. rsp_rdata/rsp_resp hold their values until the next completion.
- Constants: m_awprot = m_arprot = 3'b000, m_wstrb = 4'b1111. m_awaddr/m_araddr = latched full address.
- AXI rules: once asserted, no valid drops before its handshake and the payload does not change. Only one transaction is in flight at a time. No AW/AR accepted while busy.
- Reset (asynchronous, anytime including mid-transaction):
  - State to IDLE; all m_*valid, m_bready, m_rready, req_grant, req_done to 0.
  - rsp_rdata and rsp_resp to 0; `last` to 1.
  - The in-flight transaction is abandoned.

## Timing

- All outputs registered.
- Cycle 0: IDLE samples req_valid.
- Cycle 1: req_grant pulse together with m_awvalid/m_wvalid or m_arvalid.
- With a zero-wait slave (ready/valid high immediately):
  - Cycle 2: m_bready or m_rready high.
  - Cycle 3: req_done pulse. FSM is in IDLE in cycle 3 and may sample the next request, giving a 3-cycle turnaround.
- Each slave wait cycle on any channel adds exactly one cycle.
- m_awready and m_wready arriving in different cycles: WRESP is entered the cycle after the later handshake.
- m_bvalid/m_rvalid are never observed before the corresponding bready/rready state. They may already be high on entry and then complete in that first cycle.

## Test plan

- Reset: aresetn low mid-WRITE with m_awvalid=1 -> all valid/grant/done outputs 0 within the same cycle; after release, FSM is in IDLE with no AXI activity.
- Single write: req 0, addr 0x0, wdata 0x000000A5, zero-wait slave, bresp 2'b00 -> grant[0] at cycle 1, AW/W at cycle 1, done[0] at cycle 3, rsp_resp 00, rsp_rdata 0.
- Single read: req 1, addr 0x3, slave returns 0x0000005A after 2 wait cycles on R -> done[1] at cycle 5, rsp_rdata 0x0000005A.
- Tie fairness: both requests held continuously -> grants alternate 0,1,0,1; each completes before the next AW/AR.
- Split write handshake: m_awready at cycle 1, m_wready at cycle 4 -> m_awvalid drops after cycle 1, m_wvalid held through cycle 4 with stable m_wdata, m_bready first high at cycle 5.
- Error response: slave returns rresp 2'b10 -> done pulses with rsp_resp 2'b10 and m_rdata captured; the next request proceeds normally.

Source files
------------

// File: rtl/axi4_lite_uart_arbiter.sv
// rtl/axi4_lite_uart_arbiter.sv - two-requester round-robin AXI4-Lite master for a shared UART slave
//
// Purpose: accepts single-word read/write requests from two on-chip requesters,
// picks one round-robin, runs exactly one AXI4-Lite transaction on the UART
// slave port and returns the response (and read data) to the winner.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   req_valid/write        per-requester request strobe and direction (1 = write)
//   req_addr/req_wdata     packed per-requester payload, requester i at [i*W +: W]
//   req_grant              one-cycle pulse: request i captured
//   req_done               one-cycle pulse: transaction i finished, rsp_* valid
//   rsp_rdata/rsp_resp     read data (0 for writes) and BRESP/RRESP, held until next completion
//   m_aw*/m_w*/m_b*        AXI4-Lite write address, write data, write response channels
//   m_ar*/m_r*             AXI4-Lite read address and read data channels
module axi4_lite_uart_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_grant,
  output logic [1:0]              req_done,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic [2:0]              m_awprot,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [2:0]              m_arprot,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4
  } state_t;

  state_t                  state_q, state_d;

  logic                    awvalid_q, awvalid_d;
  logic                    wvalid_q, wvalid_d;
  logic                    arvalid_q, arvalid_d;
  logic                    bready_q, bready_d;
  logic                    rready_q, rready_d;
  logic [1:0]              grant_q, grant_d;
  logic [1:0]              done_q, done_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  // Last-granted requester; it is also the owner of the transaction in flight.
  logic                    last_q, last_d;

  logic                    pick;
  logic                    sel_write;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    start;
  logic                    aw_ok;
  logic                    w_ok;
  logic                    b_hs;
  logic                    r_hs;

  // Round-robin pick: on a tie the requester that was not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req_valid == 2'b11) begin
      pick = ~last_q;
    end else begin
      pick = req_valid[1];
    end
    sel_write = pick ? req_write[1] : req_write[0];
    sel_addr  = pick ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    sel_wdata = pick ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  end

  assign start = (state_q == ST_IDLE) && (req_valid != 2'b00);
  // A write channel counts as done once its valid has dropped or is handshaking now.
  assign aw_ok = ~awvalid_q | m_awready;
  assign w_ok  = ~wvalid_q | m_wready;
  assign b_hs  = (state_q == ST_WRESP) && bready_q && m_bvalid;
  assign r_hs  = (state_q == ST_RDATA) && rready_q && m_rvalid;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = sel_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (aw_ok && w_ok) begin
          state_d = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (b_hs) begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (m_arready) begin
          state_d = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (r_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: every output is a flop, so next-cycle values are computed here.
  always_comb begin
    awvalid_d = (start && sel_write) || ((state_q == ST_WRITE) && awvalid_q && !m_awready);
    wvalid_d  = (start && sel_write) || ((state_q == ST_WRITE) && wvalid_q && !m_wready);
    arvalid_d = (start && !sel_write) || ((state_q == ST_READ) && !m_arready);
    bready_d  = (state_d == ST_WRESP);
    rready_d  = (state_d == ST_RDATA);
    grant_d   = 2'b00;
    if (start) begin
      grant_d = pick ? 2'b10 : 2'b01;
    end
    done_d = 2'b00;
    if (b_hs || r_hs) begin
      done_d = last_q ? 2'b10 : 2'b01;
    end
    rdata_d = rdata_q;
    resp_d  = resp_q;
    if (b_hs) begin
      rdata_d = '0;
      resp_d  = m_bresp;
    end else if (r_hs) begin
      rdata_d = m_rdata;
      resp_d  = m_rresp;
    end
    addr_d  = start ? sel_addr : addr_q;
    wdata_d = start ? sel_wdata : wdata_q;
    last_d  = start ? pick : last_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      grant_q   <= 2'b00;
      done_q    <= 2'b00;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      last_q    <= 1'b1;
    end else begin
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      bready_q  <= bready_d;
      rready_q  <= rready_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      last_q    <= last_d;
    end
  end

  assign req_grant = grant_q;
  assign req_done  = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign m_awaddr  = addr_q;
  assign m_awprot  = 3'b000;
  assign m_awvalid = awvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = '1;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;
  assign m_araddr  = addr_q;
  assign m_arprot  = 3'b000;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_uart_arbiter.sv
// tb/tb_axi4_lite_uart_arbiter.sv - self-checking bench for axi4_lite_uart_arbiter
module tb_axi4_lite_uart_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            aclk;
  logic            aresetn;
  logic [1:0]      req_valid;
  logic [1:0]      req_write;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      req_grant;
  logic [1:0]      req_done;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic [AW-1:0]   m_awaddr;
  logic [2:0]      m_awprot;
  logic            m_awvalid;
  logic            m_awready = 1'b0;
  logic [DW-1:0]   m_wdata;
  logic [3:0]      m_wstrb;
  logic            m_wvalid;
  logic            m_wready = 1'b0;
  logic [1:0]      m_bresp = 2'b00;
  logic            m_bvalid = 1'b0;
  logic            m_bready;
  logic [AW-1:0]   m_araddr;
  logic [2:0]      m_arprot;
  logic            m_arvalid;
  logic            m_arready = 1'b0;
  logic [DW-1:0]   m_rdata = '0;
  logic [1:0]      m_rresp = 2'b00;
  logic            m_rvalid = 1'b0;
  logic            m_rready;

  int total = 0;
  int bad = 0;

  axi4_lite_uart_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_grant(req_grant), .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Slave model: per-channel wait counts, response code = address bits [5:4],
  // unwritten locations read back as addr ^ 0xDEADBEEF.
  int aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  bit slv_rand = 1'b0;
  logic [31:0] slv_awaddr = '0, slv_wdata = '0, slv_araddr = '0;
  logic [31:0] slv_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  always @(negedge aclk) begin
    if (m_awvalid) begin
      m_awready = (aw_cnt >= aw_wait);
      if (m_awready) begin slv_awaddr = m_awaddr; aw_cnt = 0; end else aw_cnt++;
    end else begin
      m_awready = 1'b0; aw_cnt = 0;
      if (slv_rand) aw_wait = $urandom_range(0, 3);
    end
    if (m_wvalid) begin
      m_wready = (w_cnt >= w_wait);
      if (m_wready) begin slv_wdata = m_wdata; w_cnt = 0; end else w_cnt++;
    end else begin
      m_wready = 1'b0; w_cnt = 0;
      if (slv_rand) w_wait = $urandom_range(0, 3);
    end
    if (m_bready) begin
      m_bvalid = (b_cnt >= b_wait);
      if (m_bvalid) begin
        slv_mem[slv_awaddr] = slv_wdata; m_bresp = slv_awaddr[5:4]; b_cnt = 0;
      end else begin
        m_bresp = 2'($urandom); b_cnt++;
      end
    end else begin
      m_bvalid = 1'b0; b_cnt = 0;
      if (slv_rand) b_wait = $urandom_range(0, 3);
    end
    if (m_arvalid) begin
      m_arready = (ar_cnt >= ar_wait);
      if (m_arready) begin slv_araddr = m_araddr; ar_cnt = 0; end else ar_cnt++;
    end else begin
      m_arready = 1'b0; ar_cnt = 0;
      if (slv_rand) ar_wait = $urandom_range(0, 3);
    end
    if (m_rready) begin
      m_rvalid = (r_cnt >= r_wait);
      if (m_rvalid) begin
        m_rdata = slv_mem.exists(slv_araddr) ? slv_mem[slv_araddr] : (slv_araddr ^ 32'hDEAD_BEEF);
        m_rresp = slv_araddr[5:4]; r_cnt = 0;
      end else begin
        m_rdata = $urandom; m_rresp = 2'($urandom); r_cnt++;
      end
    end else begin
      m_rvalid = 1'b0; r_cnt = 0;
      if (slv_rand) r_wait = $urandom_range(0, 3);
    end
  end

  task automatic do_reset();
    req_valid = 2'b00;
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_reset();
    total++;
    if ({req_grant, req_done, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 9'd0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {req_grant, req_done, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
    end
    total++;
    if ({rsp_rdata, rsp_resp} !== 34'd0) begin
      bad++; $display("FAIL reset_rsp: got %h/%b want 0/00", rsp_rdata, rsp_resp);
    end
    aresetn = 1'b1;
    @(negedge aclk);
    aw_wait = 20; w_wait = 20; b_wait = 0;
    req_addr[31:0] = 32'h10; req_wdata[31:0] = 32'h77; req_write = 2'b01; req_valid = 2'b01;
    @(negedge aclk);
    total++;
    if ({req_grant, m_awvalid} !== 3'b011) begin
      bad++; $display("FAIL reset_pre_grant: got %b want 011", {req_grant, m_awvalid});
    end
    req_valid = 2'b00;
    @(negedge aclk);
    total++;
    if (m_awvalid !== 1'b1) begin
      bad++; $display("FAIL reset_mid_write: awvalid got %b want 1", m_awvalid);
    end
    aresetn = 1'b0;
    #1;
    total++;
    if ({req_grant, req_done, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 9'd0) begin
      bad++; $display("FAIL reset_async: got %b want 0", {req_grant, req_done, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
    end
    @(negedge aclk);
    aresetn = 1'b1; aw_wait = 0; w_wait = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      total++;
      if ({req_grant, req_done, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready} !== 9'd0) begin
        bad++; $display("FAIL reset_quiet: cycle %0d got %b want 0", c, {req_grant, req_done, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready});
      end
    end
  endtask

  task automatic test_single_write();
    int dcyc;
    dcyc = -1;
    aw_wait = 0; w_wait = 0; b_wait = 0;
    req_addr[31:0] = 32'h0; req_wdata[31:0] = 32'h0000_00A5; req_write = 2'b01; req_valid = 2'b01;
    @(negedge aclk);
    total++;
    if ({req_grant, m_awvalid, m_wvalid, m_arvalid} !== 5'b01110) begin
      bad++; $display("FAIL wr_cycle1: got %b want 01110", {req_grant, m_awvalid, m_wvalid, m_arvalid});
    end
    total++;
    if ({m_awaddr, m_wdata, m_wstrb, m_awprot} !== {32'h0, 32'hA5, 4'hF, 3'b000}) begin
      bad++; $display("FAIL wr_payload: got %h %h %h %b want 0 a5 f 000", m_awaddr, m_wdata, m_wstrb, m_awprot);
    end
    req_valid = 2'b00;
    @(negedge aclk);
    total++;
    if ({req_grant, m_awvalid, m_wvalid, m_bready} !== 5'b00001) begin
      bad++; $display("FAIL wr_cycle2: got %b want 00001", {req_grant, m_awvalid, m_wvalid, m_bready});
    end
    for (int c = 3; c <= 12; c++) begin
      @(negedge aclk);
      if (req_done != 2'b00) begin dcyc = c; break; end
    end
    total++;
    if (dcyc != 3) begin bad++; $display("FAIL wr_done_cycle: got %0d want 3", dcyc); end
    total++;
    if ({req_done, rsp_resp, rsp_rdata} !== {2'b01, 2'b00, 32'h0}) begin
      bad++; $display("FAIL wr_rsp: got %b %b %h want 01 00 0", req_done, rsp_resp, rsp_rdata);
    end
  endtask

  task automatic test_single_read();
    int dcyc;
    dcyc = -1;
    ar_wait = 0; r_wait = 2;
    slv_mem[32'h3] = 32'h0000_005A;
    req_addr[63:32] = 32'h3; req_write = 2'b00; req_valid = 2'b10;
    @(negedge aclk);
    total++;
    if ({req_grant, m_arvalid, m_awvalid, m_araddr, m_arprot} !== {2'b10, 1'b1, 1'b0, 32'h3, 3'b000}) begin
      bad++; $display("FAIL rd_cycle1: got %b %b %b %h %b", req_grant, m_arvalid, m_awvalid, m_araddr, m_arprot);
    end
    req_valid = 2'b00;
    @(negedge aclk);
    total++;
    if ({m_arvalid, m_rready} !== 2'b01) begin
      bad++; $display("FAIL rd_cycle2: got %b want 01", {m_arvalid, m_rready});
    end
    for (int c = 3; c <= 14; c++) begin
      @(negedge aclk);
      if (req_done != 2'b00) begin dcyc = c; break; end
    end
    total++;
    if (dcyc != 5) begin bad++; $display("FAIL rd_done_cycle: got %0d want 5", dcyc); end
    total++;
    if ({req_done, rsp_resp, rsp_rdata} !== {2'b10, 2'b00, 32'h5A}) begin
      bad++; $display("FAIL rd_rsp: got %b %b %h want 10 00 5a", req_done, rsp_resp, rsp_rdata);
    end
    r_wait = 0;
  endtask

  task automatic test_split_write();
    int dcyc;
    logic [31:0] wd;
    dcyc = -1;
    wd = $urandom;
    aw_wait = 0; w_wait = 3; b_wait = 0;
    req_addr[63:32] = 32'h8; req_wdata[63:32] = wd; req_write = 2'b10; req_valid = 2'b10;
    @(negedge aclk);
    total++;
    if ({req_grant, m_awvalid, m_wvalid} !== 4'b1011) begin
      bad++; $display("FAIL split_cycle1: got %b want 1011", {req_grant, m_awvalid, m_wvalid});
    end
    req_valid = 2'b00;
    for (int c = 2; c <= 4; c++) begin
      @(negedge aclk);
      total++;
      if ({m_awvalid, m_wvalid, m_bready, m_wdata} !== {3'b010, wd}) begin
        bad++; $display("FAIL split_hold: cycle %0d got %b %h want 010 %h", c, {m_awvalid, m_wvalid, m_bready}, m_wdata, wd);
      end
    end
    @(negedge aclk);
    total++;
    if ({m_wvalid, m_bready} !== 2'b01) begin
      bad++; $display("FAIL split_bready: got %b want 01", {m_wvalid, m_bready});
    end
    for (int c = 6; c <= 14; c++) begin
      @(negedge aclk);
      if (req_done != 2'b00) begin dcyc = c; break; end
    end
    total++;
    if (dcyc != 6 || req_done !== 2'b10) begin
      bad++; $display("FAIL split_done: got cycle %0d done %b want 6 10", dcyc, req_done);
    end
    w_wait = 0;
  endtask

  task automatic test_error_resp();
    int dcyc;
    dcyc = -1;
    slv_mem[32'h20] = 32'h1234_5678;
    req_addr[31:0] = 32'h20; req_write = 2'b00; req_valid = 2'b01;
    @(negedge aclk);
    req_valid = 2'b00;
    for (int c = 2; c <= 12; c++) begin
      @(negedge aclk);
      if (req_done != 2'b00) begin dcyc = c; break; end
    end
    total++;
    if (dcyc != 3 || {req_done, rsp_resp, rsp_rdata} !== {2'b01, 2'b10, 32'h1234_5678}) begin
      bad++; $display("FAIL err_rresp: got cycle %0d %b %b %h want 3 01 10 12345678", dcyc, req_done, rsp_resp, rsp_rdata);
    end
    dcyc = -1;
    req_addr[63:32] = 32'h4; req_wdata[63:32] = 32'hCAFE; req_write = 2'b10; req_valid = 2'b10;
    @(negedge aclk);
    total++;
    if (req_grant !== 2'b10) begin bad++; $display("FAIL err_next_grant: got %b want 10", req_grant); end
    req_valid = 2'b00;
    for (int c = 2; c <= 12; c++) begin
      @(negedge aclk);
      if (req_done != 2'b00) begin dcyc = c; break; end
    end
    total++;
    if (dcyc != 3 || {req_done, rsp_resp, rsp_rdata} !== {2'b10, 2'b00, 32'h0}) begin
      bad++; $display("FAIL err_next_done: got cycle %0d %b %b %h want 3 10 00 0", dcyc, req_done, rsp_resp, rsp_rdata);
    end
  endtask

  task automatic test_tie_fairness();
    int grants, dones, owner;
    bit busy;
    int expect_w;
    grants = 0; dones = 0; owner = 0; busy = 1'b0; expect_w = 0;
    do_reset();
    req_write = 2'b00;
    req_addr = {32'h104, 32'h100};
    req_valid = 2'b11;
    for (int c = 0; c < 80 && dones < 4; c++) begin
      @(negedge aclk);
      if (req_done != 2'b00) begin
        total++;
        if (!busy || req_done !== (2'b01 << owner)) begin
          bad++; $display("FAIL tie_done: got %b busy %0d want %b", req_done, busy, 2'b01 << owner);
        end
        busy = 1'b0; dones++;
        req_addr[owner*32 +: 32] = 32'h100 + 32'(dones * 8 + owner * 4);
        req_valid[owner] = 1'b1;
      end
      if (req_grant != 2'b00) begin
        total++;
        if (busy || req_grant !== (2'b01 << expect_w)) begin
          bad++; $display("FAIL tie_grant: got %b busy %0d want %b", req_grant, busy, 2'b01 << expect_w);
        end
        busy = 1'b1; owner = expect_w; grants++;
        req_valid[expect_w] = 1'b0;
        expect_w = 1 - expect_w;
      end else if (!busy && (m_awvalid || m_arvalid)) begin
        total++; bad++; $display("FAIL tie_overlap: AXI valid while idle");
      end
    end
    total++;
    if (dones != 4) begin bad++; $display("FAIL tie_count: got %0d done want 4", dones); end
    req_valid = 2'b00;
    @(negedge aclk);
  endtask

  task automatic test_random();
    int dones, cyc, owner, w;
    bit busy;
    int mlast;
    logic [31:0] a, exp_rdata;
    logic [1:0] exp_resp;
    dones = 0; cyc = 0; owner = 0; busy = 1'b0; mlast = 1;
    exp_rdata = '0; exp_resp = 2'b00;
    slv_mem.delete(); ref_mem.delete();
    do_reset();
    slv_rand = 1'b1;
    while (dones < 60 && cyc < 4000) begin
      @(negedge aclk);
      cyc++;
      if (req_done != 2'b00) begin
        total++;
        if (!busy || {req_done, rsp_resp, rsp_rdata} !== {2'b01 << owner, exp_resp, exp_rdata}) begin
          bad++; $display("FAIL rnd_done: got %b %b %h want %b %b %h", req_done, rsp_resp, rsp_rdata, 2'b01 << owner, exp_resp, exp_rdata);
        end
        busy = 1'b0; dones++;
      end
      if (req_grant != 2'b00) begin
        w = (req_valid == 2'b11) ? 1 - mlast : (req_valid[1] ? 1 : 0);
        total++;
        if (busy || req_grant !== (2'b01 << w)) begin
          bad++; $display("FAIL rnd_grant: got %b busy %0d want %b", req_grant, busy, 2'b01 << w);
        end
        a = req_addr[w*32 +: 32];
        exp_resp = a[5:4];
        if (req_write[w]) begin
          ref_mem[a] = req_wdata[w*32 +: 32];
          exp_rdata = '0;
        end else begin
          exp_rdata = ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'hDEAD_BEEF);
        end
        busy = 1'b1; owner = w; mlast = w;
        req_valid[w] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && !(busy && owner == i) && $urandom_range(0, 2) != 0) begin
          req_addr[i*32 +: 32] = 32'($urandom_range(0, 15)) << 2;
          req_wdata[i*32 +: 32] = $urandom;
          req_write[i] = 1'($urandom);
          req_valid[i] = 1'b1;
        end
      end
    end
    total++;
    if (dones != 60) begin bad++; $display("FAIL rnd_count: got %0d completions want 60", dones); end
    slv_rand = 1'b0;
    req_valid = 2'b00;
  endtask

  initial begin
    aresetn = 1'b0;
    req_valid = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge aclk);
    test_reset();
    test_single_write();
    test_single_read();
    test_split_write();
    test_error_resp();
    test_tie_fairness();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
